// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with registered read data, occupancy count,
// full/empty flags and one-cycle overflow/underflow pulses.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16   // power of two, >= 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write_en,
  input  logic                    read_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;

  logic                  rd_ok_c;
  logic                  wr_ok_c;
  logic [CW-1:0]         count_nxt_c;

  // Acceptance: a full FIFO still takes a write when a read frees a slot this cycle.
  always_comb begin
    rd_ok_c     = read_en && !empty;
    wr_ok_c     = write_en && (!full || rd_ok_c);
    count_nxt_c = count;
    if (wr_ok_c && !rd_ok_c) begin
      count_nxt_c = count + CW'(1);
    end else if (rd_ok_c && !wr_ok_c) begin
      count_nxt_c = count - CW'(1);
    end
  end

  // Storage array is not reset; a write in a reset cycle is discarded.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok_c) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      data_out  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok_c) begin
        rd_ptr   <= rd_ptr + AW'(1);
        data_out <= mem[rd_ptr];
      end
      count     <= count_nxt_c;
      full      <= (count_nxt_c == CW'(DEPTH));
      empty     <= (count_nxt_c == CW'(0));
      overflow  <= write_en && !wr_ok_c;
      underflow <= read_en && !rd_ok_c;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed and random self-checking bench for sync_fifo against a queue model.
module tb_sync_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  logic          clk;
  logic          reset;
  logic          write_en;
  logic          read_en;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
  logic [4:0]    count;
  logic          overflow;
  logic          underflow;

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .write_en (write_en),
    .read_en  (read_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_ovf;
  logic          m_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("data_out",  32'(data_out),  32'(m_dout));
    chk("count",     32'(count),     32'(q.size()));
    chk("full",      32'(full),      32'(q.size() == DEPTH));
    chk("empty",     32'(empty),     32'(q.size() == 0));
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
  endtask

  // One clock with the given request; model predicts, outputs checked #1 after the edge.
  task automatic step(input logic we, input logic re, input logic [DW-1:0] din);
    bit rok;
    bit wok;
    write_en = we;
    read_en  = re;
    data_in  = din;
    rok = re && (q.size() != 0);
    wok = we && ((q.size() < DEPTH) || rok);
    if (rok) m_dout = q.pop_front();
    if (wok) q.push_back(din);
    m_ovf = we && !wok;
    m_unf = re && !rok;
    @(posedge clk);
    #1;
    write_en = 1'b0;
    read_en  = 1'b0;
    chk_model();
  endtask

  task automatic do_reset(input logic we, input logic re);
    reset    = 1'b1;
    write_en = we;
    read_en  = re;
    data_in  = 8'hEE;
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    write_en = 1'b0;
    read_en  = 1'b0;
    chk_model();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] nxt_in;
    logic [DW-1:0] nxt_out;
    int            wp;

    reset    = 1'b1;
    write_en = 1'b0;
    read_en  = 1'b0;
    data_in  = '0;
    @(posedge clk);
    #1;
    do_reset(1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_empty",    32'(empty),    32'h1);
    chk("rst_full",     32'(full),     32'h0);
    chk("rst_count",    32'(count),    32'h0);

    // Fill 0x01..0x10, then overflow with 0xFF
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, DW'(i));
    chk("fill_full",  32'(full),  32'h1);
    chk("fill_count", 32'(count), 32'd16);
    step(1'b1, 1'b0, 8'hFF);
    chk("ovf_pulse", 32'(overflow), 32'h1);
    chk("ovf_count", 32'(count),    32'd16);
    step(1'b0, 1'b0, 8'h00);
    chk("ovf_clear", 32'(overflow), 32'h0);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("drain_word", 32'(data_out), 32'(i));
    end
    chk("drain_empty", 32'(empty), 32'h1);

    // Underflow holds data_out; simultaneous read+write on empty
    step(1'b0, 1'b1, 8'h00);
    chk("unf_pulse", 32'(underflow), 32'h1);
    chk("unf_hold",  32'(data_out),  32'h10);
    chk("unf_count", 32'(count),     32'h0);
    step(1'b1, 1'b1, 8'hA5);
    chk("rw_empty_count", 32'(count),     32'h1);
    chk("rw_empty_unf",   32'(underflow), 32'h1);
    chk("rw_empty_nobyp", 32'(data_out),  32'h10);
    step(1'b0, 1'b1, 8'h00);
    chk("rw_empty_read", 32'(data_out), 32'hA5);

    // Full plus simultaneous read+write
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, DW'(8'h20 + i));
    step(1'b1, 1'b1, 8'h77);
    chk("rw_full_count", 32'(count),    32'd16);
    chk("rw_full_full",  32'(full),     32'h1);
    chk("rw_full_dout",  32'(data_out), 32'h20);
    chk("rw_full_ovf",   32'(overflow), 32'h0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);
    chk("rw_full_last", 32'(data_out), 32'h77);
    chk("rw_full_empty", 32'(empty), 32'h1);

    // Wrap-around with occupancy held at 2
    nxt_in  = 8'h40;
    nxt_out = 8'h40;
    step(1'b1, 1'b0, nxt_in); nxt_in++;
    step(1'b1, 1'b0, nxt_in); nxt_in++;
    for (int i = 0; i < 36; i++) begin
      step(1'b1, 1'b1, nxt_in);
      nxt_in++;
      chk("wrap_seq", 32'(data_out), 32'(nxt_out));
      nxt_out++;
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("wrap_tail", 32'(data_out), 32'(nxt_out));
      nxt_out++;
    end
    chk("wrap_empty", 32'(empty), 32'h1);

    // Reset while holding 5 words, with requests asserted
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(8'h90 + i));
    chk("hold5_count", 32'(count), 32'd5);
    do_reset(1'b1, 1'b1);
    chk("midrst_count",    32'(count),    32'h0);
    chk("midrst_empty",    32'(empty),    32'h1);
    chk("midrst_data_out", 32'(data_out), 32'h0);
    step(1'b0, 1'b1, 8'h00);
    chk("midrst_unf", 32'(underflow), 32'h1);

    // Random traffic, write-heavy then read-heavy
    for (int i = 0; i < 1000; i++) begin
      wp = (i < 500) ? 7 : 3;
      step(($urandom_range(0, 9) < wp), ($urandom_range(0, 9) >= wp), DW'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
